// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: steers one serial sample per valid cycle into
// its lane and publishes the whole frame in parallel with a one-cycle strobe.
module tdm_demux #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy,
  output logic                      err_short,
  output logic                      err_orphan
);

  localparam int unsigned FRAME_W   = CHANNELS * WIDTH;
  localparam int unsigned SHADOW_N  = CHANNELS - 1;
  localparam int unsigned LAST_LANE = CHANNELS - 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0]    shadow_q [SHADOW_N];
  logic [FRAME_W-1:0]  out_data_q;
  logic                out_valid_q, out_valid_d;
  logic                busy_q;
  logic                err_short_q, err_short_d;
  logic                err_orphan_q, err_orphan_d;

  logic                shadow_we;
  logic [SEL_W-1:0]    wr_idx;
  logic                out_load;
  logic [FRAME_W-1:0]  frame_c;

  // Next-state and strobe decode; every accepted sample lands in exactly one place.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_we    = 1'b0;
    wr_idx       = '0;
    out_load     = 1'b0;
    out_valid_d  = 1'b0;
    err_short_d  = 1'b0;
    err_orphan_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            shadow_we = 1'b1;
            wr_idx    = '0;
            sel_d     = SEL_W'(1);
            state_d   = FILL;
          end else begin
            err_orphan_d = 1'b1;
          end
        end
      end

      FILL: begin
        if (in_valid) begin
          if (in_sof) begin
            // Early SOF restarts the frame with this sample as lane 0.
            err_short_d = 1'b1;
            shadow_we   = 1'b1;
            wr_idx      = '0;
            sel_d       = SEL_W'(1);
          end else if (sel_q == SEL_W'(LAST_LANE)) begin
            out_load    = 1'b1;
            out_valid_d = 1'b1;
            sel_d       = '0;
            state_d     = IDLE;
          end else begin
            shadow_we = 1'b1;
            wr_idx    = sel_q;
            sel_d     = sel_q + SEL_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Completed frame: buffered lanes plus the final sample taken straight from the input.
  always_comb begin
    frame_c = '0;
    for (int unsigned k = 0; k < SHADOW_N; k++) begin
      frame_c[k*WIDTH +: WIDTH] = shadow_q[k];
    end
    frame_c[LAST_LANE*WIDTH +: WIDTH] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      err_short_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      busy_q       <= (state_d == FILL);
      out_valid_q  <= out_valid_d;
      err_short_q  <= err_short_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Shadow lanes: only lanes 0..CHANNELS-2 need buffering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SHADOW_N; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (shadow_we) begin
      for (int unsigned k = 0; k < SHADOW_N; k++) begin
        if (wr_idx == SEL_W'(k)) begin
          shadow_q[k] <= in_data;
        end
      end
    end
  end

  // Output register only changes on frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (out_load) begin
      out_data_q <= frame_c;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign err_short  = err_short_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed table-driven bench for tdm_demux (WIDTH=8, CHANNELS=4).
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic [1:0]  sel;
  logic        busy;
  logic        err_short;
  logic        err_orphan;

  int n_tests;
  int n_fail;

  tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sel       (sel),
    .busy      (busy),
    .err_short (err_short),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  d;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  sel;
    logic        busy;
    logic        es;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic s, input logic [7:0] d,
                     input logic ov, input logic [31:0] od, input logic [1:0] sl,
                     input logic b, input logic es, input logic eo);
    vec_t x;
    x.rst_n = r; x.in_valid = v; x.in_sof = s; x.d = d;
    x.ov = ov; x.od = od; x.sel = sl; x.busy = b; x.es = es; x.eo = eo;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    n_tests++;
    if (out_valid !== e.ov || out_data !== e.od || sel !== e.sel ||
        busy !== e.busy || err_short !== e.es || err_orphan !== e.eo) begin
      n_fail++;
      $display("FAIL vec%0d: got ov=%0b data=%h sel=%0d busy=%0b es=%0b eo=%0b, expected ov=%0b data=%h sel=%0d busy=%0b es=%0b eo=%0b",
               idx, out_valid, out_data, sel, busy, err_short, err_orphan,
               e.ov, e.od, e.sel, e.busy, e.es, e.eo);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  int pulses;
  logic [31:0] captured;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 8'h00;

    //   rst v  s  data   ov data          sel busy es eo
    add(0, 0, 0, 8'h00, 0, 32'h00000000, 0, 0, 0, 0);   // reset
    add(1, 0, 0, 8'h00, 0, 32'h00000000, 0, 0, 0, 0);   // idle hold
    // normal frame
    add(1, 1, 1, 8'h11, 0, 32'h00000000, 1, 1, 0, 0);
    add(1, 1, 0, 8'h22, 0, 32'h00000000, 2, 1, 0, 0);
    add(1, 1, 0, 8'h33, 0, 32'h00000000, 3, 1, 0, 0);
    add(1, 1, 0, 8'h44, 1, 32'h44332211, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 32'h44332211, 0, 0, 0, 0);
    // frame A with 2-cycle gaps (gap data is junk and must be ignored)
    add(1, 1, 1, 8'hA0, 0, 32'h44332211, 1, 1, 0, 0);
    add(1, 0, 0, 8'hEE, 0, 32'h44332211, 1, 1, 0, 0);
    add(1, 0, 1, 8'hEE, 0, 32'h44332211, 1, 1, 0, 0);
    add(1, 1, 0, 8'hA1, 0, 32'h44332211, 2, 1, 0, 0);
    add(1, 0, 0, 8'hEE, 0, 32'h44332211, 2, 1, 0, 0);
    add(1, 0, 0, 8'hEE, 0, 32'h44332211, 2, 1, 0, 0);
    add(1, 1, 0, 8'hA2, 0, 32'h44332211, 3, 1, 0, 0);
    add(1, 0, 0, 8'hEE, 0, 32'h44332211, 3, 1, 0, 0);
    add(1, 0, 0, 8'hEE, 0, 32'h44332211, 3, 1, 0, 0);
    add(1, 1, 0, 8'hA3, 1, 32'hA3A2A1A0, 0, 0, 0, 0);
    // back-to-back frame B
    add(1, 1, 1, 8'hB0, 0, 32'hA3A2A1A0, 1, 1, 0, 0);
    add(1, 1, 0, 8'hB1, 0, 32'hA3A2A1A0, 2, 1, 0, 0);
    add(1, 1, 0, 8'hB2, 0, 32'hA3A2A1A0, 3, 1, 0, 0);
    add(1, 1, 0, 8'hB3, 1, 32'hB3B2B1B0, 0, 0, 0, 0);
    // early SOF
    add(1, 1, 1, 8'h01, 0, 32'hB3B2B1B0, 1, 1, 0, 0);
    add(1, 1, 0, 8'h02, 0, 32'hB3B2B1B0, 2, 1, 0, 0);
    add(1, 1, 1, 8'h10, 0, 32'hB3B2B1B0, 1, 1, 1, 0);
    add(1, 1, 0, 8'h20, 0, 32'hB3B2B1B0, 2, 1, 0, 0);
    add(1, 1, 0, 8'h30, 0, 32'hB3B2B1B0, 3, 1, 0, 0);
    add(1, 1, 0, 8'h40, 1, 32'h40302010, 0, 0, 0, 0);
    // orphan sample, then a clean frame
    add(1, 1, 0, 8'h55, 0, 32'h40302010, 0, 0, 0, 1);
    add(1, 0, 0, 8'h00, 0, 32'h40302010, 0, 0, 0, 0);
    add(1, 1, 1, 8'h61, 0, 32'h40302010, 1, 1, 0, 0);
    add(1, 1, 0, 8'h62, 0, 32'h40302010, 2, 1, 0, 0);
    add(1, 1, 0, 8'h63, 0, 32'h40302010, 3, 1, 0, 0);
    add(1, 1, 0, 8'h64, 1, 32'h64636261, 0, 0, 0, 0);
    // reset mid-frame
    add(1, 1, 1, 8'h11, 0, 32'h64636261, 1, 1, 0, 0);
    add(1, 1, 0, 8'h22, 0, 32'h64636261, 2, 1, 0, 0);
    add(0, 0, 0, 8'h00, 0, 32'h00000000, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 32'h00000000, 0, 0, 0, 0);
    add(1, 1, 1, 8'h0A, 0, 32'h00000000, 1, 1, 0, 0);
    add(1, 1, 0, 8'h0B, 0, 32'h00000000, 2, 1, 0, 0);
    add(1, 1, 0, 8'h0C, 0, 32'h00000000, 3, 1, 0, 0);
    add(1, 1, 0, 8'h0D, 1, 32'h0D0C0B0A, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 32'h0D0C0B0A, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0, 32'h0D0C0B0A, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      drive(vecs[i].in_valid, vecs[i].in_sof, vecs[i].d);
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset mid-frame must clear state without a clock edge.
    drive(1'b1, 1'b1, 8'h77);
    drive(1'b1, 1'b0, 8'h78);
    check("pre_async_busy", 32'(busy), 32'd1);
    check("pre_async_sel", 32'(sel), 32'd2);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_sel", 32'(sel), 32'd0);
    check("async_data", out_data, 32'h00000000);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One frame must yield exactly one strobe within a bounded window.
    pulses   = 0;
    captured = 32'h0;
    drive(1'b1, 1'b1, 8'hC1);
    if (out_valid) begin pulses++; captured = out_data; end
    drive(1'b1, 1'b0, 8'hC2);
    if (out_valid) begin pulses++; captured = out_data; end
    drive(1'b1, 1'b0, 8'hC3);
    if (out_valid) begin pulses++; captured = out_data; end
    drive(1'b1, 1'b0, 8'hC4);
    if (out_valid) begin pulses++; captured = out_data; end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 8'h00);
      if (out_valid) begin pulses++; captured = out_data; end
    end
    check("frame_c_pulses", 32'(pulses), 32'd1);
    check("frame_c_data", captured, 32'hC4C3C2C1);
    check("frame_c_hold", out_data, 32'hC4C3C2C1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Error strobes are mutually exclusive.
  always @(negedge clk) begin
    if (rst_n && err_short && err_orphan) begin
      n_tests++;
      n_fail++;
      $display("FAIL err_exclusive: got es=%0b eo=%0b, expected not both set", err_short, err_orphan);
    end
  end

endmodule
